// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage: load funct3 encodings,
// the zero-register index and the load-tracker / write-source enumerations.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [4:0]  REG_X0       = 5'd0;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    LS_IDLE,
    LS_WAIT
  } ld_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_ALU
  } wr_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small holding FIFO for ALU results displaced by load responses.
// Simultaneous push and pop are allowed, including when full.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU results and load responses onto the regfile
// write port, with load extraction and an ordering FIFO for displaced ALU results.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid_i,
  input  logic            alu_rd_en_i,
  input  logic [4:0]      alu_rd_idx_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            ld_req_valid_i,
  output logic            ld_req_ready_o,
  input  logic [4:0]      ld_rd_idx_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            ld_busy_o,
  output logic [4:0]      ld_rd_idx_o,
  output logic            stall_o,
  output logic            rd_en_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] rd_wdata_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = 5 + XLEN;

  ld_state_t       state, state_nxt;
  logic [2:0]      ld_funct3_q;
  logic [1:0]      ld_addr_lo_q;
  logic            ld_accept;
  logic            ld_resp;
  logic            alu_write;
  wr_src_t         src;
  logic [4:0]      sel_idx;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] ld_data;

  logic             fifo_push;
  logic             fifo_pop;
  logic [ENT_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= LS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LS_IDLE: if (ld_req_valid_i) state_nxt = LS_WAIT;
      LS_WAIT: if (dmem_rvalid_i)  state_nxt = LS_IDLE;
      default: state_nxt = LS_IDLE;
    endcase
  end

  assign ld_accept      = (state == LS_IDLE) && ld_req_valid_i;
  assign ld_resp        = (state == LS_WAIT) && dmem_rvalid_i;
  assign ld_busy_o      = (state == LS_WAIT);
  assign ld_req_ready_o = (state == LS_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd_idx_o  <= '0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
    end else if (ld_accept) begin
      ld_rd_idx_o  <= ld_rd_idx_i;
      ld_funct3_q  <= ld_funct3_i;
      ld_addr_lo_q <= ld_addr_lo_i;
    end
  end

  assign ld_shifted = dmem_rdata_i >> {ld_addr_lo_q, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_funct3_q)
      LD_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      LD_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      LD_LW:   ld_data = ld_shifted;
      LD_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      LD_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      default: ld_data = '0;
    endcase
  end

  assign alu_write = alu_valid_i && alu_rd_en_i;

  // Load response beats the FIFO; a direct ALU write is only legal with an
  // empty FIFO so older buffered results always retire first.
  always_comb begin
    src = SRC_NONE;
    if (ld_resp)          src = SRC_LOAD;
    else if (!fifo_empty) src = SRC_FIFO;
    else if (alu_write)   src = SRC_ALU;
  end

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    unique case (src)
      SRC_LOAD: begin sel_idx = ld_rd_idx_o;         sel_data = ld_data;             end
      SRC_FIFO: begin sel_idx = fifo_head[ENT_W-1 -: 5]; sel_data = fifo_head[XLEN-1:0]; end
      SRC_ALU:  begin sel_idx = alu_rd_idx_i;        sel_data = alu_result_i;        end
      default:  begin sel_idx = '0;                  sel_data = '0;                  end
    endcase
  end

  assign fifo_pop  = (src == SRC_FIFO);
  assign fifo_push = alu_write && (src != SRC_ALU) && (!fifo_full || fifo_pop);
  assign stall_o   = (fifo_count == CNT_W'(FIFO_DEPTH));

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({alu_rd_idx_i, alu_result_i}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_o    <= 1'b0;
      rd_idx_o   <= '0;
      rd_wdata_o <= '0;
    end else begin
      rd_en_o <= (src != SRC_NONE) && (sel_idx != REG_X0);
      if (src != SRC_NONE) begin
        rd_idx_o   <= sel_idx;
        rd_wdata_o <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of load-extraction vectors plus
// hand sequences for collisions, FIFO ordering, reset mid-load and x0 writes.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_i, alu_rd_en_i;
  logic [4:0]  alu_rd_idx_i;
  logic [31:0] alu_result_i;
  logic        ld_req_valid_i, ld_req_ready_o;
  logic [4:0]  ld_rd_idx_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_addr_lo_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        ld_busy_o;
  logic [4:0]  ld_rd_idx_o;
  logic        stall_o, rd_en_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_rd_en_i(alu_rd_en_i),
    .alu_rd_idx_i(alu_rd_idx_i), .alu_result_i(alu_result_i),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
    .ld_rd_idx_i(ld_rd_idx_i), .ld_funct3_i(ld_funct3_i), .ld_addr_lo_i(ld_addr_lo_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .ld_busy_o(ld_busy_o), .ld_rd_idx_o(ld_rd_idx_o), .stall_o(stall_o),
    .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_wdata_o(rd_wdata_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; alu_rd_en_i = 0; alu_rd_idx_i = '0; alu_result_i = '0;
    ld_req_valid_i = 0; ld_rd_idx_i = '0; ld_funct3_i = '0; ld_addr_lo_i = '0;
    dmem_rvalid_i = 0; dmem_rdata_i = '0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
    ld_req_valid_i = 1; ld_rd_idx_i = rd; ld_funct3_i = f3; ld_addr_lo_i = alo;
    tick();
    ld_req_valid_i = 0;
    chk("ld_busy_after_req", ld_busy_o, 1);
    chk("ld_rd_idx_capture", ld_rd_idx_o, rd);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    alu_valid_i = 1; alu_rd_en_i = 1; alu_rd_idx_i = rd; alu_result_i = val;
  endtask

  task automatic alu_off();
    alu_valid_i = 0; alu_rd_en_i = 0;
  endtask

  task automatic expect_write(input string name, input logic [4:0] rd, input logic [31:0] val);
    chk({name, "_en"}, rd_en_o, 1);
    chk({name, "_idx"}, rd_idx_o, rd);
    chk({name, "_data"}, rd_wdata_o, val);
  endtask

  initial begin
    vecs[0]  = '{5'd7,  LD_LB,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[1]  = '{5'd7,  LD_LBU, 2'd3, 32'h80FF_0000, 32'h0000_0080};
    vecs[2]  = '{5'd7,  LD_LHU, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
    vecs[3]  = '{5'd6,  LD_LH,  2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
    vecs[4]  = '{5'd3,  LD_LW,  2'd0, 32'h80FF_0000, 32'h80FF_0000};
    vecs[5]  = '{5'd4,  LD_LB,  2'd2, 32'h80FF_0000, 32'hFFFF_FFFF};
    vecs[6]  = '{5'd4,  LD_LB,  2'd1, 32'h80FF_0000, 32'h0000_0000};
    vecs[7]  = '{5'd20, LD_LH,  2'd0, 32'h1234_5678, 32'h0000_5678};
    vecs[8]  = '{5'd21, LD_LB,  2'd0, 32'h1234_5678, 32'h0000_0078};
    vecs[9]  = '{5'd22, LD_LHU, 2'd2, 32'h1234_5678, 32'h0000_1234};
    vecs[10] = '{5'd23, 3'b011, 2'd0, 32'h1234_5678, 32'h0000_0000};
    vecs[11] = '{5'd24, 3'b110, 2'd1, 32'h1234_5678, 32'h0000_0000};

    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_rd_idx", rd_idx_o, 0);
    chk("rst_rd_wdata", rd_wdata_o, 0);
    chk("rst_busy", ld_busy_o, 0);
    chk("rst_ld_rd_idx", ld_rd_idx_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_ready", ld_req_ready_o, 1);
    reset = 0;
    tick();

    // Plain ALU write, latency 1
    alu(5'd5, 32'h0000_1234);
    tick();
    alu_off();
    expect_write("alu_x5", 5'd5, 32'h0000_1234);
    tick();
    chk("alu_x5_then_idle", rd_en_o, 0);

    // ALU valid without rd_en causes no write
    alu_valid_i = 1; alu_rd_en_i = 0; alu_rd_idx_i = 5'd9; alu_result_i = 32'h99;
    tick();
    alu_off();
    chk("alu_no_rd_en", rd_en_o, 0);

    // Load extraction table, rvalid three cycles after request
    for (int unsigned i = 0; i < 12; i++) begin
      issue_load(vecs[i].rd, vecs[i].f3, vecs[i].alo);
      chk("ld_ready_low_wait", ld_req_ready_o, 0);
      tick(); tick();
      dmem_rvalid_i = 1; dmem_rdata_i = vecs[i].rdata;
      tick();
      dmem_rvalid_i = 0;
      expect_write($sformatf("ld_vec%0d", i), vecs[i].rd, vecs[i].exp);
      chk("ld_back_idle", ld_req_ready_o, 1);
      tick();
    end

    // Load response collides with ALU write
    issue_load(5'd7, LD_LW, 2'd0);
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hCAFE_0007;
    alu(5'd8, 32'h11);
    tick();
    dmem_rvalid_i = 0; alu_off();
    expect_write("coll_ld_x7", 5'd7, 32'hCAFE_0007);
    tick();
    expect_write("coll_alu_x8", 5'd8, 32'h11);
    tick();
    chk("coll_done", rd_en_o, 0);

    // Two collisions with ALU every cycle fill the FIFO
    issue_load(5'd10, LD_LW, 2'd0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hAAAA_0001;
    alu(5'd11, 32'h0B);
    tick();
    dmem_rvalid_i = 0;
    expect_write("fill_ld_x10", 5'd10, 32'hAAAA_0001);
    chk("fill_stall_1", stall_o, 0);
    ld_req_valid_i = 1; ld_rd_idx_i = 5'd12; ld_funct3_i = LD_LW; ld_addr_lo_i = 2'd0;
    alu(5'd13, 32'h0D);
    tick();
    ld_req_valid_i = 0;
    expect_write("fill_fifo_x11", 5'd11, 32'h0B);
    chk("fill_stall_2", stall_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hCCCC_0002;
    alu(5'd14, 32'h0E);
    tick();
    dmem_rvalid_i = 0; alu_off();
    expect_write("fill_ld_x12", 5'd12, 32'hCCCC_0002);
    chk("fill_stall_full", stall_o, 1);
    tick();
    expect_write("drain_x13", 5'd13, 32'h0D);
    chk("drain_stall_drop", stall_o, 0);
    tick();
    expect_write("drain_x14", 5'd14, 32'h0E);
    tick();
    chk("drain_done", rd_en_o, 0);

    // Reset while waiting abandons the load
    issue_load(5'd9, LD_LW, 2'd0);
    reset = 1;
    tick();
    reset = 0;
    chk("rstw_busy", ld_busy_o, 0);
    chk("rstw_ready", ld_req_ready_o, 1);
    chk("rstw_ld_idx", ld_rd_idx_o, 0);
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h0000_FFFF;
    tick();
    dmem_rvalid_i = 0;
    chk("rstw_no_write", rd_en_o, 0);
    tick();
    chk("rstw_no_write2", rd_en_o, 0);
    chk("rstw_still_idle", ld_busy_o, 0);

    // Writes to x0 never enable the port
    alu(5'd0, 32'h0000_DEAD);
    tick();
    alu_off();
    chk("x0_alu_en", rd_en_o, 0);
    issue_load(5'd0, LD_LW, 2'd0);
    tick();
    chk("x0_wait_en", rd_en_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234_0000;
    tick();
    dmem_rvalid_i = 0;
    chk("x0_ld_en", rd_en_o, 0);
    chk("x0_ld_idle", ld_req_ready_o, 1);
    chk("x0_ld_busy", ld_busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
